add_share_arbiter: RTL and testbench

- Shares one combinational N-bit carry-increment adder (carry_increment_generic, cin tied 0) among NUM_REQ requesters.
- Round-robin arbitration feeds a 2-stage pipeline: operand register, then result register.
- Valid/ready on both sides; sits between client engines and the arithmetic datapath.

---
 rtl/add_share_arb_pkg.sv | 26 ++
 rtl/carry_increment_generic.sv | 29 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/add_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_add_share_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/add_share_arb_pkg.sv
// Shared constants and helpers for the shared-adder arbiter slice.
// Optional statistics counters are enabled with the ADD_SHARE_ARB_STATS_EN macro.
package add_share_arb_pkg;

    localparam int N_DEF          = 64;
    localparam int BLOCK_SIZE_DEF = 4;
    localparam int NUM_REQ_DEF    = 4;
    localparam int ID_W_DEF       = 2;
    localparam int STATS_W        = 16;

    // Widest packed request bus the slice helper can handle (16 requesters x 128 bits).
    localparam int MAX_N     = 128;
    localparam int MAX_REQ   = 16;
    localparam int MAX_BUS_W = MAX_N * MAX_REQ;

    function automatic logic [MAX_N-1:0] operand_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int unsigned          idx,
        input int unsigned          width
    );
        logic [MAX_BUS_W-1:0] shifted;
        shifted = bus >> (idx * width);
        return shifted[MAX_N-1:0];
    endfunction

endpackage

// File: rtl/carry_increment_generic.sv
// Carry-increment adder: each block adds with carry-in 0, then increments when
// the incoming block carry is set.
module carry_increment_generic #(
    parameter int N          = 64,
    parameter int BLOCK_SIZE = 4
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);
    localparam int NB = N / BLOCK_SIZE;

    logic [NB:0] carry;

    assign carry[0] = cin_i;

    for (genvar g = 0; g < NB; g++) begin : g_blk
        logic [BLOCK_SIZE:0] raw;
        assign raw = {1'b0, a_i[g*BLOCK_SIZE +: BLOCK_SIZE]} + {1'b0, b_i[g*BLOCK_SIZE +: BLOCK_SIZE]};
        assign sum_o[g*BLOCK_SIZE +: BLOCK_SIZE] = raw[BLOCK_SIZE-1:0] + BLOCK_SIZE'(carry[g]);
        // An all-ones block sum overflows exactly when the increment is applied.
        assign carry[g+1] = raw[BLOCK_SIZE] | (carry[g] & (&raw[BLOCK_SIZE-1:0]));
    end

    assign cout_o = carry[NB];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr_i, wrapping,
// when enabled. Purely combinational.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);
    int   idx;
    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en_i && !found && req_i[IDX_W'(idx)]) begin
                found                = 1'b1;
                gnt_o[IDX_W'(idx)]   = 1'b1;
                gnt_idx_o            = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/add_share_arbiter.sv
// Shares one carry-increment adder among NUM_REQ requesters through a
// round-robin grant and a 2-stage pipeline. Stats counters: ADD_SHARE_ARB_STATS_EN.
module add_share_arbiter
    import add_share_arb_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int ID_W       = ID_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*N-1:0] req_a_i,
    input  logic [NUM_REQ*N-1:0] req_b_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [ID_W-1:0]      rsp_id_o,
    output logic [N-1:0]         rsp_sum_o,
    output logic                 rsp_cout_o
`ifdef ADD_SHARE_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_W-1:0] grant_cnt_o,
    output logic [STATS_W-1:0]         stall_cnt_o
`endif
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic               s1_valid_q, s1_valid_d;
    logic [N-1:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [N-1:0]       rsp_sum_q, rsp_sum_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;

    logic               adv1, adv2, any_gnt;
    logic [NUM_REQ-1:0] gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic [N-1:0]       add_sum;
    logic               add_cout;

    assign adv2    = !rsp_valid_q || rsp_ready_i;
    assign adv1    = !s1_valid_q || adv2;
    assign any_gnt = |gnt;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(PTR_W)) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .en_i      (adv1),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    carry_increment_generic #(.N(N), .BLOCK_SIZE(BLOCK_SIZE)) u_add (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_id_d     = s1_id_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_id_d    = rsp_id_q;
        if (adv1) begin
            s1_valid_d = any_gnt;
            if (any_gnt) begin
                s1_a_d   = N'(operand_slice(MAX_BUS_W'(req_a_i), 32'(gnt_idx), N));
                s1_b_d   = N'(operand_slice(MAX_BUS_W'(req_b_i), 32'(gnt_idx), N));
                s1_id_d  = ID_W'(gnt_idx);
                rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            end
        end
        if (adv2) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_sum_d  = add_sum;
                rsp_cout_d = add_cout;
                rsp_id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_id_q     <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_id_q     <= s1_id_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign req_ready_o = gnt;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_cout_o  = rsp_cout_q;
    assign rsp_id_o    = rsp_id_q;

`ifdef ADD_SHARE_ARB_STATS_EN
    logic [STATS_W-1:0] grant_cnt_q [NUM_REQ];
    logic [STATS_W-1:0] stall_cnt_q;

    // Saturating counters: grants per requester, and cycles where someone waited in vain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt[k] && grant_cnt_q[k] != '1) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + STATS_W'(1);
                end
            end
            if ((|req_valid_i) && !any_gnt && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + STATS_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt_out
        assign grant_cnt_o[k*STATS_W +: STATS_W] = grant_cnt_q[k];
    end
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter: reset, arithmetic, round-robin order,
// backpressure and mid-flight reset; stats counters when ADD_SHARE_ARB_STATS_EN is set.
module tb_add_share_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_sum;
    logic         rsp_cout;
`ifdef ADD_SHARE_ARB_STATS_EN
    logic [63:0]  grant_cnt;
    logic [15:0]  stall_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    add_share_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_sum_o   (rsp_sum),
        .rsp_cout_o  (rsp_cout)
`ifdef ADD_SHARE_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt),
        .stall_cnt_o (stall_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        rst = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        vectors++;
        if (rsp_sum !== 64'h0 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
            miscompares++; $display("[TB] FAIL reset_rsp_data: got sum=%h cout=%0b id=%0d want 0/0/0", rsp_sum, rsp_cout, rsp_id);
        end
        vectors++;
        if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_req_ready: got %b want 0000", req_ready); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        req_a[63:0] = 64'h1;
        req_b[63:0] = 64'h2;
        req_valid = 4'b0001;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL single_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_early: rsp_valid got %0b want 0", rsp_valid); end
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 64'd3 || rsp_cout !== 1'b0 || rsp_id !== 2'd0) begin
            miscompares++; $display("[TB] FAIL single_rsp: got v=%0b sum=%h cout=%0b id=%0d want 1/3/0/0", rsp_valid, rsp_sum, rsp_cout, rsp_id);
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_drain: rsp_valid got %0b want 0", rsp_valid); end
    endtask

    task automatic test_arith;
        int          tk [4]   = '{1, 2, 3, 0};
        logic [63:0] ta [4]   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 64'h0FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        logic [63:0] tb_ [4]  = '{64'h1, 64'h0FED_CBA9_8765_4321, 64'h1, 64'h8000_0000_0000_0001};
        logic [63:0] ts [4]   = '{64'h0, 64'h2222_2222_2222_2211, 64'h1000_0000_0000_0000, 64'h1};
        logic        tc [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            req_a[tk[i]*64 +: 64] = ta[i];
            req_b[tk[i]*64 +: 64] = tb_[i];
            req_valid = 4'b0001 << tk[i];
            #1;
            vectors++;
            if (req_ready !== (4'b0001 << tk[i])) begin
                miscompares++; $display("[TB] FAIL arith_grant[%0d]: got %b want %b", i, req_ready, 4'b0001 << tk[i]);
            end
            tick();
            req_valid = 4'b0000;
            tick();
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_sum !== ts[i] || rsp_cout !== tc[i] || rsp_id !== 2'(tk[i])) begin
                miscompares++; $display("[TB] FAIL arith_rsp[%0d]: got v=%0b sum=%h cout=%0b id=%0d want 1/%h/%0b/%0d",
                                        i, rsp_valid, rsp_sum, rsp_cout, rsp_id, ts[i], tc[i], tk[i]);
            end
            tick();
        end
    endtask

    task automatic test_round_robin;
        logic [64:0] exp [4];
        int          g;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req_a[k*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(k + 1);
            req_b[k*64 +: 64] = 64'hF000_0000_0000_0000 + 64'(k);
            exp[k] = {1'b0, req_a[k*64 +: 64]} + {1'b0, req_b[k*64 +: 64]};
        end
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (req_ready !== (4'b0001 << (i % 4))) begin
                miscompares++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", i, req_ready, 4'b0001 << (i % 4));
            end
            if (i >= 2) begin
                g = (i - 2) % 4;
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || {rsp_cout, rsp_sum} !== exp[g]) begin
                    miscompares++; $display("[TB] FAIL rr_rsp[%0d]: got v=%0b id=%0d res=%h want 1/%0d/%h",
                                            i, rsp_valid, rsp_id, {rsp_cout, rsp_sum}, g, exp[g]);
                end
            end
            tick();
        end
        req_valid = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            g = 2 + i;
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || {rsp_cout, rsp_sum} !== exp[g]) begin
                miscompares++; $display("[TB] FAIL rr_drain[%0d]: got v=%0b id=%0d res=%h want 1/%0d/%h",
                                        i, rsp_valid, rsp_id, {rsp_cout, rsp_sum}, g, exp[g]);
            end
            tick();
        end
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_empty: rsp_valid got %0b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back_stall;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req_a[k*64 +: 64] = 64'hAAAA_0000_0000_0000 + 64'(k);
            req_b[k*64 +: 64] = 64'h5555_0000_0000_1000;
        end
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL bp_grant0: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0110;
        #1;
        vectors++;
        if (req_ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL bp_grant1: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0100;
        #1;
        for (int c = 2; c < 5; c++) begin
            vectors++;
            if (req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL bp_blocked[%0d]: got %b want 0000", c, req_ready); end
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 64'hFFFF_0000_0000_1000 || rsp_cout !== 1'b0) begin
                miscompares++; $display("[TB] FAIL bp_hold[%0d]: got v=%0b id=%0d sum=%h want 1/0/ffff000000001000", c, rsp_valid, rsp_id, rsp_sum);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL bp_release_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 64'hFFFF_0000_0000_1001) begin
            miscompares++; $display("[TB] FAIL bp_rsp1: got v=%0b id=%0d sum=%h want 1/1/ffff000000001001", rsp_valid, rsp_id, rsp_sum);
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== 64'hFFFF_0000_0000_1002) begin
            miscompares++; $display("[TB] FAIL bp_rsp2: got v=%0b id=%0d sum=%h want 1/2/ffff000000001002", rsp_valid, rsp_id, rsp_sum);
        end
        tick();
        vectors++;
        if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_empty: rsp_valid got %0b want 0", rsp_valid); end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        req_a[63:0]   = 64'd5;  req_b[63:0]   = 64'd6;
        req_a[127:64] = 64'd7;  req_b[127:64] = 64'd8;
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        #1;
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 64'd11) begin
            miscompares++; $display("[TB] FAIL mid_prefill: got v=%0b sum=%h want 1/b", rsp_valid, rsp_sum);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 64'h0 || rsp_cout !== 1'b0 || rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL mid_async_clear: got v=%0b sum=%h cout=%0b id=%0d rdy=%b want all 0",
                                    rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_stale[%0d]: rsp_valid got %0b want 0", c, rsp_valid); end
        end
        req_valid = 4'b1111;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL mid_ptr_reset: got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 64'd11) begin
            miscompares++; $display("[TB] FAIL mid_after: got v=%0b id=%0d sum=%h want 1/0/b", rsp_valid, rsp_id, rsp_sum);
        end
        tick();
    endtask

`ifdef ADD_SHARE_ARB_STATS_EN
    task automatic test_stats;
        do_reset();
        req_a[191:128] = 64'd1;
        req_b[191:128] = 64'd1;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        repeat (10) tick();
        rsp_ready = 1'b0;
        repeat (3) tick();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (grant_cnt[47:32] !== 16'd10) begin miscompares++; $display("[TB] FAIL stats_grant2: got %0d want 10", grant_cnt[47:32]); end
        vectors++;
        if (grant_cnt[31:0] !== 32'h0 || grant_cnt[63:48] !== 16'h0) begin
            miscompares++; $display("[TB] FAIL stats_others: got %h want zeros outside req2", grant_cnt);
        end
        vectors++;
        if (stall_cnt !== 16'd3) begin miscompares++; $display("[TB] FAIL stats_stall: got %0d want 3", stall_cnt); end
        req_valid = 4'b0100;
        repeat (65530) tick();
        req_valid = 4'b0000;
        #1;
        vectors++;
        if (grant_cnt[47:32] !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL stats_saturate: got %h want ffff", grant_cnt[47:32]); end
        vectors++;
        if (stall_cnt !== 16'd3) begin miscompares++; $display("[TB] FAIL stats_stall_hold: got %0d want 3", stall_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_arith();
        test_round_robin();
        test_back_to_back_stall();
        test_reset_midflight();
`ifdef ADD_SHARE_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
